serial_tx: RTL

Serial frame transmitter that drives the one-bit `q` line sampled by the team's flop-based serial receivers. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out LSB first. Each word is framed by a start bit (0) and a stop bit (1), with every bit held for CLKS_PER_BIT clocks. It sits between a producer (register file or FIFO read side) and the serial line.

---
 rtl/serial_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, stop bit, each held CLKS_PER_BIT clocks.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module serial_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                // load_ready is registered as (state == IDLE), so valid alone completes the handshake
                if (load_valid) begin
                    state_d = StStart;
                    shift_d = data_in;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from next state so that every output is a plain flop.
    always_comb begin
        case (state_d)
            StStart:  q_d = 1'b0;
            StData:   q_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            StParity: q_d = parity_d;
`endif
            default:  q_d = 1'b1;
        endcase
        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StIdle);
        done_d  = (state_d == StStop) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            q_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign q          = q_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule
